// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage with a two-word credit window.
// Buffers returned words in a 2-entry FIFO and squashes stale responses on redirect.
package inst_fetch_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef enum logic [2:0] {
        SEL_PC_ADD4  = 3'd0,
        SEL_PC_JAL   = 3'd1,
        SEL_PC_JALR  = 3'd2,
        SEL_PC_MTVEC = 3'd3,
        SEL_PC_MEPC  = 3'd4
    } sel_pc_t;
endpackage

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] code,
    output logic [31:0] pc,
    output logic        code_valid,
    input  logic        code_ready,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        branch_taken,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc
);

    addr_t      fetch_pc;
    addr_t      resp_pc;
    logic [1:0] out_cnt;
    logic [1:0] disc_cnt;
    logic [1:0] fifo_cnt;
    logic       wr_ptr;
    logic       rd_ptr;
    addr_t      fifo_pc [2];
    data_t      fifo_code [2];

    sel_pc_t    sel;
    logic       handshake;
    logic       redirect;
    logic       rsp;
    logic       keep;
    logic       xfer;
    addr_t      target;

    assign sel        = sel_pc_t'(pc_sel);
    assign code_valid = (fifo_cnt != 2'd0);
    assign code       = code_valid ? fifo_code[rd_ptr] : '0;
    assign pc         = code_valid ? fifo_pc[rd_ptr] : '0;
    assign handshake  = code_valid && code_ready;
    assign redirect   = handshake && ((sel != SEL_PC_ADD4) || branch_taken);

    // Responses with nothing outstanding are ignored; stale ones are never kept.
    assign rsp  = imem_rvalid && (out_cnt != 2'd0);
    assign keep = rsp && (disc_cnt == 2'd0) && !redirect;

    // Credit counts both in-flight requests and buffered words.
    assign imem_req  = !rst && !redirect
                     && (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'd2);
    assign imem_addr = fetch_pc;
    assign xfer      = imem_req && imem_gnt;

    // Redirect target selection; a taken branch uses pc+imm.
    always_comb begin
        target = pc + imm;
        unique case (1'b1)
            (sel == SEL_PC_JALR):  target = (rs1_data + imm) & ~32'h1;
            (sel == SEL_PC_MTVEC): target = mtvec;
            (sel == SEL_PC_MEPC):  target = mepc;
            default:               target = pc + imm;
        endcase
    end

    // Fetch pointer, credit counters and FIFO occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            out_cnt  <= 2'd0;
            disc_cnt <= 2'd0;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= target;
            resp_pc  <= target;
            fifo_cnt <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            out_cnt  <= out_cnt - {1'b0, rsp};
            disc_cnt <= out_cnt - {1'b0, rsp};
        end else begin
            if (xfer)
                fetch_pc <= fetch_pc + 32'd4;
            out_cnt <= out_cnt + {1'b0, xfer} - {1'b0, rsp};
            if (rsp && (disc_cnt != 2'd0))
                disc_cnt <= disc_cnt - 2'd1;
            if (keep) begin
                wr_ptr  <= ~wr_ptr;
                resp_pc <= resp_pc + 32'd4;
            end
            if (handshake)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, keep} - {1'b0, handshake};
        end
    end

    // FIFO payload; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (keep) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_code[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch.
// Expected pcs are queued per step and popped as decode consumes words.
`timescale 1ns/1ps
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] code;
    logic [31:0] pc;
    logic        code_valid;
    logic        code_ready;
    logic [2:0]  pc_sel;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        branch_taken;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_code;
    logic [31:0] w_pc;
    logic        w_valid;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] jmp_pc = 32'hFFFF_FFFF;
    sel_pc_t     jmp_sel = SEL_PC_ADD4;
    logic        jmp_taken = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        chk_tgt = 1'b0;
    logic [31:0] lat = 32'd1;

    inst_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .code(code), .pc(pc), .code_valid(code_valid),
        .code_ready(code_ready), .pc_sel(pc_sel), .imm(imm),
        .rs1_data(rs1_data), .branch_taken(branch_taken),
        .mtvec(mtvec), .mepc(mepc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(1'b1), .imem_rvalid(1'b0),
        .imem_rdata(32'h0),
        .code(w_code), .pc(w_pc), .code_valid(w_valid),
        .code_ready(1'b0), .pc_sel(3'd0), .imm(32'h0),
        .rs1_data(32'h0), .branch_taken(1'b0),
        .mtvec(32'h0), .mepc(32'h0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode-side control: redirect only on the chosen pc.
    always_comb begin
        pc_sel = SEL_PC_ADD4;
        branch_taken = 1'b0;
        if (code_valid && (pc == jmp_pc)) begin
            pc_sel = jmp_sel;
            branch_taken = jmp_taken;
        end
    end

    // Memory model: in-order responses lat cycles after each grant.
    typedef struct packed {
        logic [31:0] due;
        logic [31:0] d;
    } rsp_t;
    rsp_t        mq[$];
    logic [31:0] cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            cyc <= 32'd0;
            imem_rvalid <= 1'b0;
            imem_rdata <= 32'h0;
        end else begin
            if (imem_req && imem_gnt)
                mq.push_back({cyc + lat - 32'd1, mem_f(imem_addr)});
            cyc <= cyc + 32'd1;
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata <= mq[0].d;
                void'(mq.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata <= 32'hDEAD_BEEF;
            end
        end
    end

    // Decode accepts only words the scoreboard is waiting for.
    initial begin
        code_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            code_ready = (exp_q.size() != 0);
        end
    end

    // Scoreboard: compare each accepted word; check fetch after redirects.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (chk_tgt) begin
                chk("redir_next_req", {31'b0, imem_req}, 32'd1);
                chk("redir_next_addr", imem_addr, tgt);
                chk_tgt = 1'b0;
            end
            if (code_valid && code_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_word observed pc=%h expected none", pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", pc, e);
                    chk("sb_code", code, mem_f(e));
                    if (pc_sel != SEL_PC_ADD4 || branch_taken) begin
                        chk("redir_cycle_req", {31'b0, imem_req}, 32'd0);
                        chk_tgt = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic set_jump(input logic [31:0] at, input sel_pc_t s,
                            input logic tk, input logic [31:0] t);
        jmp_pc = at;
        jmp_sel = s;
        jmp_taken = tk;
        tgt = t;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain observed left=%0d expected 0", exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b1;
        imm = 32'h0;
        rs1_data = 32'h0;
        mtvec = 32'h80;
        mepc = 32'h44;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, code_valid}, 32'd0);
        chk("rst_code", code, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_wrap_req", {31'b0, w_req}, 32'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("lat_c0_valid", {31'b0, code_valid}, 32'd0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("lat_c1_valid", {31'b0, code_valid}, 32'd0);
        chk("wrap_req1", {31'b0, w_req}, 32'd1);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        @(negedge clk);
        chk("lat_c2_valid", {31'b0, code_valid}, 32'd1);
        chk("lat_c2_pc", pc, 32'h0);
        chk("lat_c2_code", code, mem_f(32'h0));

        repeat (10) @(negedge clk);
        chk("bp_req", {31'b0, imem_req}, 32'd0);
        chk("bp_valid", {31'b0, code_valid}, 32'd1);
        chk("bp_pc", pc, 32'h0);

        lat = 32'd2;
        imm = 32'h100;
        set_jump(32'h10, SEL_PC_JAL, 1'b0, 32'h110);
        push_seq(32'h0, 5);
        push_seq(32'h110, 2);
        wait_empty();

        imm = 32'h2;
        rs1_data = 32'h2001;
        set_jump(32'h118, SEL_PC_JALR, 1'b0, 32'h2002);
        push_seq(32'h118, 1);
        push_seq(32'h2002, 1);
        wait_empty();

        imm = 32'h7777;
        set_jump(32'h2006, SEL_PC_MTVEC, 1'b0, 32'h80);
        push_seq(32'h2006, 1);
        push_seq(32'h80, 1);
        wait_empty();

        set_jump(32'h84, SEL_PC_MEPC, 1'b0, 32'h44);
        push_seq(32'h84, 1);
        push_seq(32'h44, 2);
        wait_empty();

        repeat (6) @(negedge clk);
        chk("pre_rst_valid", {31'b0, code_valid}, 32'd1);
        chk("pre_rst_pc", pc, 32'h4C);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, code_valid}, 32'd0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);

        imm = 32'hFFFF_FFF8;
        set_jump(32'h20, SEL_PC_ADD4, 1'b1, 32'h18);
        push_seq(32'h0, 9);
        push_seq(32'h18, 2);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; one clock; asynchronous, active-high.
REQ-004 imem_req  output  1  instruction memory request; a transfer occurs in any cycle with imem_req && imem_gnt.
REQ-005 imem_addr  output  32 (addr_t)  request address; sampled only when imem_gnt is high.
REQ-006 imem_gnt  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  response valid; responses arrive in order, at least 1 cycle after their grant.
REQ-008 imem_rdata  input  32 (data_t)  instruction word returned with imem_rvalid.
REQ-009 code  output  32 (data_t)  instruction word presented to decode.
REQ-010 pc  output  32 (addr_t)  address of code.
REQ-011 code_valid  output  1  code/pc valid.
REQ-012 code_ready  input  1  decode consumes code/pc; handshake = code_valid && code_ready.
REQ-013 pc_sel  input  sel_pc_t  next-PC select from decode for the instruction being handshaken.
REQ-014 imm  input  32 (data_t)  immediate from decode.
REQ-015 rs1_data  input  32 (data_t)  rs1 value, used for JALR.
REQ-016 branch_taken  input  1  branch condition true for the instruction being handshaken.
REQ-017 mtvec  input  32  trap vector from csr.
REQ-018 mepc  input  32  exception return address from csr.

Function
REQ-019 Internal state: fetch_pc register; 2-entry FIFO of {pc, code}; outstanding counter (0..2); discard counter (0..2).
REQ-020 imem_req = 1 when not in reset, no redirect this cycle, and outstanding + FIFO count < 2; imem_addr = fetch_pc.
REQ-021 On a grant: outstanding increments; fetch_pc advances by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-022 On imem_rvalid with discard = 0: {pc of oldest outstanding request, imem_rdata} is pushed into the FIFO, and outstanding decrements.
REQ-023 On imem_rvalid with discard > 0: the word is dropped, and both discard and outstanding decrement.
REQ-024 Grant and rvalid in the same cycle: the outstanding counter is net unchanged.
REQ-025 code_valid = FIFO non-empty; code/pc = FIFO head; the head pops on handshake.
REQ-026 Minimum latency: grant in cycle N, rvalid in cycle N+1, code_valid in cycle N+2.
REQ-027 Redirect = handshake && (pc_sel != SEL_PC_ADD4 || branch_taken).
REQ-028 Redirect targets: SEL_PC_JAL -> pc+imm; SEL_PC_JALR -> (rs1_data+imm) & ~32'h1; SEL_PC_MTVEC -> mtvec; SEL_PC_MEPC -> mepc; SEL_PC_ADD4 with branch_taken -> pc+imm.
REQ-029 All target arithmetic is 32-bit, modulo 2^32.
REQ-030 In a redirect cycle: imem_req = 0; the FIFO is flushed; discard is set to the outstanding count including any response arriving that same cycle; fetch_pc is set to the target.
REQ-031 After a redirect, the first request at the target is issued in the next cycle.
REQ-032 A response arriving in a redirect cycle is always dropped.
REQ-033 A non-redirect handshake does not alter fetch_pc.
REQ-034 imem_rvalid with outstanding = 0 is a protocol error and is ignored.
REQ-035 code_valid never asserts for any word whose request preceded the most recent redirect.

Reset
REQ-036 While rst is high: fetch_pc = RESET_PC; FIFO, outstanding and discard = 0; imem_req = 0; code_valid = 0; code = 0; pc = 0.
REQ-037 rst asserted mid-operation aborts all state immediately; responses to pre-reset requests are the memory's responsibility.
REQ-038 First request after reset: imem_req = 1 with imem_addr = RESET_PC in the first cycle after rst falls.

Verification
REQ-039 Streaming: gnt=1 and rvalid one cycle after each grant, code_ready=1 -> pc sequence 0x0, 0x4, 0x8 …, code equals memory contents, no gaps beyond the credit limit.
REQ-040 Backpressure: code_ready=0 for 10 cycles -> exactly 2 words buffered, imem_req=0, no word lost or duplicated after release.
REQ-041 JAL at pc=0x10 with imm=0x100 and 2 requests outstanding -> both stale words dropped, next code_valid shows pc=0x110.
REQ-042 JALR with rs1_data=0x2001, imm=0x2 -> next fetch address 0x2002; MTVEC=0x80 -> 0x80; MEPC=0x44 -> 0x44; branch_taken with imm=-8 at pc=0x20 -> 0x18.
REQ-043 Wrap: RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
REQ-044 Reset mid-stream with FIFO full -> code_valid=0 immediately, fetch restarts at RESET_PC.
